// File: rtl/pulse_link_pkg.sv
// Shared constants for the pulse-counter readout link: FSM encoding,
// default word geometry and the output buffer entry layout {perr, ch, data}.
package pulse_link_pkg;

  localparam int         PL_DATA_W  = 8;
  localparam int         PL_CH_W    = 3;
  localparam logic [2:0] PL_LAST_CH = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;

  typedef struct packed {
    logic                 perr;
    logic [PL_CH_W-1:0]   ch;
    logic [PL_DATA_W-1:0] data;
  } pl_entry_t;

  function automatic int pl_entry_w(input int data_w, input int ch_w);
    return 1 + ch_w + data_w;
  endfunction

endpackage

// File: rtl/pulse_link_fifo2.sv
// Two-entry valid/ready buffer with registered head; a push into a full
// buffer is accepted only when the head is popped in the same cycle.
module pulse_link_fifo2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  output logic         push_ok_o,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop_s;
  logic         push_ok_s;

  assign pop_s     = (cnt_q != 2'd0) & ready_i;
  assign push_ok_s = push_i & ((cnt_q != 2'd2) | pop_s);
  assign push_ok_o = push_ok_s;
  assign valid_o   = (cnt_q != 2'd0);
  assign dout_o    = head_q;

  // next-state of occupancy and storage
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_ok_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = din_i;
        end else begin
          tail_d = din_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // storage registers; reset empties the buffer so valid_o drops at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= {W{1'b0}};
      tail_q <= {W{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/pulse_frame_deserializer.sv
// Receive side of the pulse-counter link: shifts in MSB-first words after SL,
// tags them with the channel and queues them. Option macro: PULSE_DESER_PARITY_EN.
module pulse_frame_deserializer
  import pulse_link_pkg::*;
#(
  parameter int              DATA_W  = PL_DATA_W,
  parameter int              CH_W    = PL_CH_W,
  parameter logic [CH_W-1:0] LAST_CH = CH_W'(PL_LAST_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              sl,
  input  logic [CH_W-1:0]   ch_addr,
  input  logic              sdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr,
  output logic              parity_err,
  output logic              out_perr
);

`ifdef PULSE_DESER_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam int               ENTRY_W  = pl_entry_w(DATA_W, CH_W);

  logic [1:0]         state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_set_s, push_s, push_ok_s, perr_s;
  logic [ENTRY_W-1:0] head_s;

`ifdef PULSE_DESER_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
  assign perr_s     = (^shreg_q) ^ par_q;
  assign parity_err = parity_err_q;
`else
  assign perr_s     = 1'b0;
  assign parity_err = 1'b0;
`endif

  // frame FSM: SL always restarts a word, even mid-word or during STORE
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ch_d        = ch_q;
    frame_set_s = 1'b0;
    push_s      = 1'b0;
`ifdef PULSE_DESER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sl) begin
          ch_d      = ch_addr;
          bit_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sl) begin
          frame_set_s = 1'b1;
          ch_d        = ch_addr;
          bit_cnt_d   = {CNT_W{1'b0}};
        end else if (tick) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef PULSE_DESER_PARITY_EN
          if (bit_cnt_q == LAST_BIT) begin
            par_d = sdata;
          end else begin
            shreg_d = {shreg_q[DATA_W-2:0], sdata};
          end
`else
          shreg_d = {shreg_q[DATA_W-2:0], sdata};
`endif
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_STORE: begin
        push_s = 1'b1;
        if (sl) begin
          ch_d      = ch_addr;
          bit_cnt_d = {CNT_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sticky error flags: a set in the same cycle as err_clr wins
  always_comb begin
    frame_err_d  = frame_set_s | (frame_err_q & ~err_clr);
    overrun_d    = (push_s & ~push_ok_s) | (overrun_q & ~err_clr);
    frame_done_d = push_ok_s & (ch_q == LAST_CH);
`ifdef PULSE_DESER_PARITY_EN
    parity_err_d = (push_s & perr_s) | (parity_err_q & ~err_clr);
`endif
  end

  // state and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= {DATA_W{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      ch_q         <= {CH_W{1'b0}};
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PULSE_DESER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_q         <= ch_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
`ifdef PULSE_DESER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  pulse_link_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push_s),
    .din_i     ({perr_s, ch_q, shreg_q}),
    .ready_i   (out_ready),
    .push_ok_o (push_ok_s),
    .valid_o   (out_valid),
    .dout_o    (head_s)
  );

  assign {out_perr, out_ch, out_data} = head_s;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pulse_frame_deserializer.sv
// Directed self-checking bench for pulse_frame_deserializer (both parity builds).
module tb_pulse_frame_deserializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, sl = 1'b0, sdata = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [2:0] ch_addr = 3'd0;
  logic       out_valid, frame_done, frame_err, overrun, parity_err, out_perr;
  logic [7:0] out_data;
  logic [2:0] out_ch;

  int total = 0;
  int bad = 0;
  logic [10:0] pops[$];
  int fd_cnt = 0;
  int fd_ch3 = 0;

  pulse_frame_deserializer dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sl(sl), .ch_addr(ch_addr),
    .sdata(sdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .frame_done(frame_done), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr), .parity_err(parity_err), .out_perr(out_perr)
  );

  always #5 clk = ~clk;

  // pop and frame_done logger, sampled just after the falling edge
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) pops.push_back({out_ch, out_data});
    if (frame_done) begin
      fd_cnt++;
      if (out_valid && out_ch == 3'd3) fd_ch3++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [7:0] d, input logic par_bad);
    for (int i = 7; i >= 0; i--) begin
      tick = 1'b1; sdata = d[i]; cyc();
    end
`ifdef PULSE_DESER_PARITY_EN
    tick = 1'b1; sdata = (^d) ^ par_bad; cyc();
`endif
    tick = 1'b0; sdata = 1'b0;
  endtask

  task automatic send_word(input logic [2:0] ch, input logic [7:0] d, input logic par_bad);
    sl = 1'b1; ch_addr = ch; cyc();
    sl = 1'b0;
    shift_bits(d, par_bad);
  endtask

  task automatic test_reset;
    cyc(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if ({out_ch, out_data} !== 11'd0) begin bad++; $display("FAIL rst_head got=%h want=0", {out_ch, out_data}); end
    total++; if ({frame_done, frame_err, overrun, parity_err, out_perr} !== 5'd0) begin bad++;
      $display("FAIL rst_flags got=%b want=00000", {frame_done, frame_err, overrun, parity_err, out_perr}); end
    reset_n = 1'b1;
    cyc(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_rel_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_capture;
    out_ready = 1'b0;
    tick = 1'b1; cyc(2); tick = 1'b0;
    send_word(3'b100, 8'hB2, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cap_early got=%b want=0", out_valid); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 8'hB2) begin bad++; $display("FAIL cap_data got=%h want=b2", out_data); end
    total++; if (out_ch !== 3'b100) begin bad++; $display("FAIL cap_ch got=%0d want=4", out_ch); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL cap_pop got=%b want=0", out_valid); end
  endtask

  task automatic test_scan;
    logic [2:0] chs[6];
    logic [7:0] ds[6];
    chs = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
    ds  = '{8'h11, 8'h3C, 8'hE7, 8'h80, 8'h01, 8'hFF};
    pops.delete(); fd_cnt = 0; fd_ch3 = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_word(chs[k], ds[k], 1'b0);
    cyc(4);
    out_ready = 1'b0;
    total++; if (pops.size() !== 6) begin bad++; $display("FAIL scan_count got=%0d want=6", pops.size()); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (k >= pops.size() || pops[k] !== {chs[k], ds[k]}) begin bad++;
        $display("FAIL scan_word%0d got=%h want=%h", k, (k < pops.size()) ? pops[k] : 11'h7FF, {chs[k], ds[k]}); end
    end
    total++; if (fd_cnt !== 1) begin bad++; $display("FAIL scan_fd_count got=%0d want=1", fd_cnt); end
    total++; if (fd_ch3 !== 1) begin bad++; $display("FAIL scan_fd_timing got=%0d want=1", fd_ch3); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL scan_no_ferr got=%b want=0", frame_err); end
  endtask

  task automatic test_abort;
    pops.delete();
    out_ready = 1'b1;
    sl = 1'b1; ch_addr = 3'd2; cyc(); sl = 1'b0;
    for (int i = 0; i < 3; i++) begin tick = 1'b1; sdata = 1'b1; cyc(); end
    tick = 1'b0;
    send_word(3'b001, 8'h5A, 1'b0);
    cyc(4);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_ferr got=%b want=1", frame_err); end
    total++; if (pops.size() !== 1) begin bad++; $display("FAIL abort_count got=%0d want=1", pops.size()); end
    total++; if (pops.size() < 1 || pops[0] !== {3'd1, 8'h5A}) begin bad++;
      $display("FAIL abort_word got=%h want=%h", (pops.size() > 0) ? pops[0] : 11'h7FF, {3'd1, 8'h5A}); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_clr got=%b want=0", frame_err); end
    sl = 1'b1; ch_addr = 3'd6; cyc(); sl = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    sl = 1'b1; err_clr = 1'b1; cyc(); sl = 1'b0; err_clr = 1'b0;
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL set_wins got=%b want=1", frame_err); end
    shift_bits(8'hC3, 1'b0);
    cyc(3);
    total++; if (pops.size() < 2 || pops[1] !== {3'd6, 8'hC3}) begin bad++;
      $display("FAIL abort_word2 got=%h want=%h", (pops.size() > 1) ? pops[1] : 11'h7FF, {3'd6, 8'hC3}); end
    out_ready = 1'b0;
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
  endtask

  task automatic test_backpressure;
    pops.delete(); fd_cnt = 0;
    out_ready = 1'b0;
    send_word(3'd2, 8'hA1, 1'b0);
    send_word(3'd5, 8'h4E, 1'b0);
    send_word(3'd3, 8'h77, 1'b0);
    cyc(3);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
    total++; if (out_valid !== 1'b1 || {out_ch, out_data} !== {3'd2, 8'hA1}) begin bad++;
      $display("FAIL bp_head got=%b/%h want=1/%h", out_valid, {out_ch, out_data}, {3'd2, 8'hA1}); end
    total++; if (fd_cnt !== 0) begin bad++; $display("FAIL bp_drop_fd got=%0d want=0", fd_cnt); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_clr got=%b want=0", overrun); end
    out_ready = 1'b1; cyc(3); out_ready = 1'b0;
    total++; if (pops.size() !== 2) begin bad++; $display("FAIL bp_count got=%0d want=2", pops.size()); end
    total++; if (pops.size() < 2 || pops[0] !== {3'd2, 8'hA1} || pops[1] !== {3'd5, 8'h4E}) begin bad++;
      $display("FAIL bp_order got=%h,%h want=%h,%h", (pops.size() > 0) ? pops[0] : 11'h7FF,
               (pops.size() > 1) ? pops[1] : 11'h7FF, {3'd2, 8'hA1}, {3'd5, 8'h4E}); end
  endtask

  task automatic test_full_pushpop;
    pops.delete();
    out_ready = 1'b0;
    send_word(3'd1, 8'h12, 1'b0);
    send_word(3'd2, 8'h34, 1'b0);
    send_word(3'd4, 8'h56, 1'b0);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    cyc(2);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fpp_overrun got=%b want=0", overrun); end
    total++; if ({out_ch, out_data} !== {3'd2, 8'h34}) begin bad++;
      $display("FAIL fpp_head got=%h want=%h", {out_ch, out_data}, {3'd2, 8'h34}); end
    out_ready = 1'b1; cyc(3); out_ready = 1'b0;
    total++; if (pops.size() !== 3 || pops[2] !== {3'd4, 8'h56}) begin bad++;
      $display("FAIL fpp_order got=%0d/%h want=3/%h", pops.size(),
               (pops.size() > 2) ? pops[2] : 11'h7FF, {3'd4, 8'h56}); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_word(3'd0, 8'hAA, 1'b0);
    send_word(3'd7, 8'hBB, 1'b0);
    cyc(2);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", out_valid); end
    sl = 1'b1; ch_addr = 3'd5; cyc(); sl = 1'b0;
    for (int i = 0; i < 3; i++) begin tick = 1'b1; sdata = 1'b1; cyc(); end
    tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_async got=%b want=0", out_valid); end
    cyc(2);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin tick = 1'b1; sdata = 1'b1; cyc(); end
    tick = 1'b0;
    cyc(3);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale got=%b want=0", out_valid); end
    send_word(3'd3, 8'h69, 1'b0);
    cyc();
    total++; if (out_valid !== 1'b1 || {out_ch, out_data} !== {3'd3, 8'h69}) begin bad++;
      $display("FAIL rm_fresh got=%b/%h want=1/%h", out_valid, {out_ch, out_data}, {3'd3, 8'h69}); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_single got=%b want=0", out_valid); end
  endtask

  task automatic test_parity;
    out_ready = 1'b0;
    send_word(3'd2, 8'h5A, 1'b1);
    cyc();
`ifdef PULSE_DESER_PARITY_EN
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err got=%b want=1", parity_err); end
    total++; if (out_perr !== 1'b1 || out_data !== 8'h5A) begin bad++;
      $display("FAIL par_word got=%b/%h want=1/5a", out_perr, out_data); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    send_word(3'd2, 8'h5B, 1'b0);
    cyc();
    total++; if (out_perr !== 1'b0 || parity_err !== 1'b1) begin bad++;
      $display("FAIL par_good got=%b/%b want=0/1", out_perr, parity_err); end
`else
    total++; if (parity_err !== 1'b0 || out_perr !== 1'b0) begin bad++;
      $display("FAIL par_tied got=%b/%b want=0/0", parity_err, out_perr); end
    total++; if (out_data !== 8'h5A) begin bad++; $display("FAIL par_data got=%h want=5a", out_data); end
`endif
    out_ready = 1'b1; cyc(2); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_scan();
    test_abort();
    test_backpressure();
    test_full_pushpop();
    test_reset_mid();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_frame_deserializer.md
Name: pulse_frame_deserializer

Overview:
- Receive end of the multichannel pulse-counter readout link; counterpart of the channel sequencer that drives mux address, SL load strobe and overflow ticks.
- Captures the serial count word shifted out after each SL strobe, tags it with the channel address present at SL, and queues it in a 2-entry output buffer with valid/ready handshake.
- Flags framing and overrun errors and pulses frame_done when the last channel of a scan has been queued.

Parameters:
- DATA_W, 8, bits per channel word, MSB first.
- CH_W, 3, channel address width.
- LAST_CH, 3'b011, channel address that closes a scan.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  shift enable, one-cycle pulse (sequencer ovf | ovf_RTC)
- sl  in  1  load strobe; marks start of a word
- ch_addr  in  CH_W  sequencer mux address {a2,a1,a0}, sampled when sl=1
- sdata  in  1  serial data, sampled on tick
- out_valid  out  1  buffer head valid
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_data  out  DATA_W  head word
- out_ch  out  CH_W  head channel tag
- frame_done  out  1  one-cycle pulse when a LAST_CH word is queued
- frame_err  out  1  sticky: sl during an unfinished word
- overrun  out  1  sticky: word dropped because buffer full
- err_clr  in  1  clears frame_err, overrun (and parity_err); set wins over clear in the same cycle

Behaviour:
- Reset: state IDLE; shift register, bit_cnt, ch_q = 0; buffer empty; all outputs 0.
- State machine: IDLE, SHIFT, STORE.
- IDLE: sl=1 -> ch_q <= ch_addr, bit_cnt <= 0, go SHIFT. tick without sl is ignored.
- SHIFT, on tick & !sl: shreg <= {shreg[DATA_W-2:0], sdata}, bit_cnt++.
- SHIFT: the tick that samples bit DATA_W-1 -> go STORE.
- SHIFT, sl=1 (with or without tick): abort partial word, set frame_err, reload ch_q, bit_cnt <= 0, stay in SHIFT. sdata is not sampled in that cycle.
- STORE: one cycle. Push {ch_q, shreg} into the buffer -> IDLE.
  - Buffer full with no pop this cycle: word dropped, overrun <= 1.
  - sl arriving in STORE is honoured as in IDLE; the next state is SHIFT.
- frame_done: asserted in the cycle after a successful push with ch_q == LAST_CH. Not asserted for dropped words.
- Latency: last-bit tick in cycle N -> STORE in N+1 -> out_valid=1 in N+2 (empty buffer).
- Buffer: 2-entry FIFO, registered outputs.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when full is allowed: pop frees the slot, no overrun.
  - Head holds stable while out_valid & !out_ready.
- bit_cnt width: clog2(DATA_W+1). It never wraps; it is reset by sl.
- reset_n low mid-word or with data queued: everything is discarded immediately; out_valid falls asynchronously.

Optional Feature:
- Macro: PULSE_DESER_PARITY_EN.
- Defined:
  - One extra even-parity bit is shifted after the DATA_W data bits; STORE follows the parity tick.
  - Mismatch sets sticky output parity_err, and the word is still queued.
  - The buffer entry carries a perr bit, presented on output out_perr.
- Undefined:
  - Ports parity_err and out_perr exist and are tied to 0.
  - The frame is exactly DATA_W bits.

Decomposition:
- Package pulse_link_pkg holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, STORE=2'd2);
  - default DATA_W, CH_W, LAST_CH constants;
  - the buffer entry layout {perr, ch, data}.
- One sub-module: pulse_link_fifo2, the 2-entry valid/ready buffer parameterised on entry width.

Test Plan:
- Word capture: sl with ch_addr=3'b100, then 8 ticks carrying 1,0,1,1,0,0,1,0 -> out_data=8'hB2, out_ch=3'b100, out_valid two cycles after the last tick.
- Scan completion: words for channels 0, 4, 0, 1, 2, 3 with out_ready=1 -> six pops in order; frame_done pulses once, one cycle after the ch=3 push.
- Framing abort: sl, 3 ticks, sl with ch_addr=3'b001, then 8 ticks of 8'h5A -> frame_err=1, single output word 8'h5A with ch 1.
- Backpressure: out_ready=0, three complete words -> first two are held in order, third is dropped, overrun=1; err_clr clears overrun; out_ready=1 drains the two held words.
- Full push/pop: buffer full, pop and push in the same cycle -> no overrun, ordering kept.
- Reset mid-word and with 2 entries queued: assert reset_n=0 -> out_valid=0 at once, no stale word after release. With PULSE_DESER_PARITY_EN, a bad parity bit -> parity_err=1, out_perr=1 on that word.
